// File: rtl/uart_tx_queue_pkg.sv
// Shared types for the UART transmit queue: byte width and transmit FSM states.
// Optional occupancy outputs are enabled by defining UART_TX_QUEUE_LEVEL_EN.
package uart_tx_queue_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Handshake bundle between the core/UART side and uart_tx_queue.
// level/almost_full only exist when UART_TX_QUEUE_LEVEL_EN is defined.
interface uart_tx_queue_if
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH = 16
);

  logic [UART_BYTE_W-1:0] wr_data;
  logic                   wr_en;
  logic                   full;
  logic                   empty;
  logic                   overflow;
  logic                   flush;
  logic [UART_BYTE_W-1:0] send_data;
  logic                   send;
  logic                   send_busy;
  logic                   tx_idle;
`ifdef UART_TX_QUEUE_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
  logic                   almost_full;

  modport master (
    output wr_data, wr_en, flush, send_busy,
    input  full, empty, overflow, send_data, send, tx_idle, level, almost_full
  );

  modport slave (
    input  wr_data, wr_en, flush, send_busy,
    output full, empty, overflow, send_data, send, tx_idle, level, almost_full
  );
`else
  modport master (
    output wr_data, wr_en, flush, send_busy,
    input  full, empty, overflow, send_data, send, tx_idle
  );

  modport slave (
    input  wr_data, wr_en, flush, send_busy,
    output full, empty, overflow, send_data, send, tx_idle
  );
`endif

endinterface

// File: rtl/uart_tx_queue_fifo.sv
// Byte storage for uart_tx_queue: wrap-around pointers with an extra MSB,
// full/empty/level derived from the pointer registers, sticky overflow.
module uart_tx_queue_fifo
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [UART_BYTE_W-1:0]   wr_data,
  input  logic                     wr_en,
  input  logic                     flush,
  input  logic                     pop,
  output logic [UART_BYTE_W-1:0]   rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   push;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // flush wins over a same-cycle write; full is judged before any same-cycle pop
  assign push = wr_en && !full && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue in front of uart_controller: buffers writes and issues one
// send pulse per byte, paced on send_busy. UART_TX_QUEUE_LEVEL_EN adds level/almost_full.
//
// state     | meaning
// IDLE      | waiting for a queued byte and send_busy low
// ISSUE     | send pulse high, byte presented on send_data
// WAIT_BUSY | waiting for uart_controller to raise send_busy
// WAIT_DONE | waiting for send_busy to fall
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH    = 16
`ifdef UART_TX_QUEUE_LEVEL_EN
  ,
  parameter int AFULL_TH = 14
`endif
) (
  input logic           clk,
  input logic           rst,
  uart_tx_queue_if.slave q
);

  localparam int LW = $clog2(DEPTH) + 1;

  uart_tx_state_t         state;
  uart_tx_state_t         state_n;
  logic                   issue;
  logic                   send_r;
  logic [UART_BYTE_W-1:0] send_data_r;
  logic [UART_BYTE_W-1:0] head;
  logic                   empty;
  logic [LW-1:0]          level;

  uart_tx_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (q.wr_data),
    .wr_en    (q.wr_en),
    .flush    (q.flush),
    .pop      (issue),
    .rd_data  (head),
    .full     (q.full),
    .empty    (empty),
    .overflow (q.overflow),
    .level    (level)
  );

  // a flush in IDLE discards the head instead of issuing it
  assign issue = (state == IDLE) && !empty && !q.send_busy && !q.flush;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (issue) state_n = ISSUE;
      ISSUE:     state_n = WAIT_BUSY;
      WAIT_BUSY: if (q.send_busy) state_n = WAIT_DONE;
      WAIT_DONE: if (!q.send_busy) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      send_r      <= 1'b0;
      send_data_r <= '0;
    end else begin
      state  <= state_n;
      send_r <= issue;
      if (issue)
        send_data_r <= head;
    end
  end

  assign q.empty     = empty;
  assign q.send      = send_r;
  assign q.send_data = send_data_r;
  assign q.tx_idle   = (level == '0) && (state == IDLE) && !q.send_busy;

`ifdef UART_TX_QUEUE_LEVEL_EN
  localparam logic [LW-1:0] AFULL_LV = LW'(AFULL_TH);

  assign q.level       = level;
  assign q.almost_full = (level >= AFULL_LV);
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed scenarios plus random traffic, scored against
// a queue-based model and a behavioural send_busy responder.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy_m = 1'b0;
  logic hold_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit         ov_m = 1'b0;
  bit         frame_open = 1'b0;
  bit         seen_busy = 1'b0;
  bit         prev_send = 1'b0;
  int         edge_idx = 0;
  int         fall_idx = -1;
  int         sent_cnt = 0;
  logic [7:0] last_sent = 8'h00;

  uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

  assign bus.send_busy = busy_m | hold_busy;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // uart_controller stand-in: busy for a random number of cycles after each send
  initial begin
    forever begin
      @(negedge clk);
      if (bus.send === 1'b1 && rst === 1'b1) begin
        busy_m = 1'b1;
        repeat ($urandom_range(2, 10)) @(negedge clk);
        busy_m = 1'b0;
      end
    end
  end

  // reference model and scoreboard, updated once per clock edge
  initial begin
    logic       p_wr, p_fl, p_busy, p_rst;
    logic [7:0] p_d;
    int         pre_size;
    forever begin
      @(posedge clk);
      p_wr = bus.wr_en; p_d = bus.wr_data; p_fl = bus.flush;
      p_busy = bus.send_busy; p_rst = rst;
      pre_size = mq.size();
      #1;
      edge_idx++;
      if (!p_rst || !rst) begin
        mq.delete();
        ov_m = 1'b0; frame_open = 1'b0; seen_busy = 1'b0; prev_send = 1'b0;
      end else begin
        if (frame_open) begin
          if (p_busy) seen_busy = 1'b1;
          else if (seen_busy) begin
            frame_open = 1'b0;
            fall_idx = edge_idx;
          end
        end
        if (bus.send === 1'b1) begin
          chk("send_pulse_width", prev_send, 0);
          chk("send_with_data", pre_size != 0, 1);
          chk("send_busy_low", p_busy, 0);
          chk("send_gap", (!frame_open && edge_idx > fall_idx), 1);
          if (mq.size() != 0) begin
            last_sent = mq.pop_front();
            chk("send_data", bus.send_data, last_sent);
          end
          sent_cnt++;
          frame_open = 1'b1;
          seen_busy = 1'b0;
        end
        prev_send = bus.send;
        if (p_fl) begin
          mq.delete();
          ov_m = 1'b0;
        end else if (p_wr) begin
          if (pre_size == DEPTH) ov_m = 1'b1;
          else mq.push_back(p_d);
        end
      end
      chk("empty", bus.empty, mq.size() == 0);
      chk("full", bus.full, mq.size() == DEPTH);
      chk("overflow", bus.overflow, ov_m);
`ifdef UART_TX_QUEUE_LEVEL_EN
      chk("level", bus.level, mq.size());
      chk("almost_full", bus.almost_full, mq.size() >= 14);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.wr_en = 1'b1; bus.wr_data = b;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      if (mq.size() == 0 && bus.tx_idle === 1'b1 && bus.send_busy === 1'b0) done = 1'b1;
    end
    chk(tag, done, 1);
  endtask

  task automatic wait_send(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (bus.send === 1'b1) got = 1'b1;
    end
    chk(tag, got, 1);
  endtask

  initial begin
    int base;
    bit got;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0;

    // 1: reset values
    #1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_send", bus.send, 0);
    chk("rst_send_data", bus.send_data, 0);
    chk("rst_tx_idle", bus.tx_idle, 1);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    // 2: single byte latency
    bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    tick();
    bus.wr_en = 1'b0;
    chk("lat_e0_send", bus.send, 0);
    tick();
    chk("lat_e1_send", bus.send, 1);
    chk("lat_e1_data", bus.send_data, 8'h55);
    tick();
    chk("lat_e2_send", bus.send, 0);
    chk("lat_hold_data", bus.send_data, 8'h55);
    wait_idle("single_idle");
    chk("single_tx_idle", bus.tx_idle, 1);

    // 3: fill to full while uart busy, then overflow, then drain in order
    base = sent_cnt;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    chk("burst_full", bus.full, 1);
    write_byte(8'hEE);
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_still_full", bus.full, 1);
    hold_busy = 1'b0;
    wait_idle("burst_drain");
    chk("burst_sent", sent_cnt - base, 16);
    chk("burst_last", last_sent, 8'h0F);
    chk("ovf_sticky", bus.overflow, 1);

    // 4: flush with a byte in flight
    base = sent_cnt;
    hold_busy = 1'b1;
    write_byte(8'h31); write_byte(8'h32); write_byte(8'h33);
    hold_busy = 1'b0;
    wait_send("flush_inflight_send");
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_ovf", bus.overflow, 0);
    chk("flush_empty", bus.empty, 1);
    wait_idle("flush_drain");
    chk("flush_sent", sent_cnt - base, 1);
    chk("flush_byte", last_sent, 8'h31);

    // 5: flush and write in the same cycle
    base = sent_cnt;
    hold_busy = 1'b1;
    write_byte(8'h41); write_byte(8'h42);
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h77;
    tick();
    bus.flush = 1'b0; bus.wr_en = 1'b0;
    chk("fw_empty", bus.empty, 1);
    chk("fw_ovf", bus.overflow, 0);
    hold_busy = 1'b0;
    repeat (30) tick();
    chk("fw_nothing_sent", sent_cnt - base, 0);

    // 6: reset during a send pulse
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(8'h60 + 8'(i));
    hold_busy = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #2;
      if (bus.send === 1'b1) got = 1'b1;
    end
    chk("rst_mid_send_seen", got, 1);
    rst = 1'b0;
    #1;
    chk("rstm_send", bus.send, 0);
    chk("rstm_empty", bus.empty, 1);
    chk("rstm_full", bus.full, 0);
    chk("rstm_ovf", bus.overflow, 0);
    chk("rstm_send_data", bus.send_data, 0);
    chk("rstm_tx_idle", bus.tx_idle, 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    base = sent_cnt;
    write_byte(8'hA5);
    wait_idle("post_rst_idle");
    chk("post_rst_sent", sent_cnt - base, 1);
    chk("post_rst_byte", last_sent, 8'hA5);

    // random traffic with occasional flushes
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 300; i++) begin
        bus.wr_en   = ($urandom_range(0, 99) < 60);
        bus.wr_data = 8'($urandom);
        bus.flush   = ($urandom_range(0, 99) < 2);
        tick();
      end
      bus.wr_en = 1'b0; bus.flush = 1'b0;
      wait_idle("rand_drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
